// File: rtl/id_ex_operand_stage.sv
// id_ex_operand_stage: decode-to-execute register stage with EX/MEM/WB operand bypass,
// load-use stall and a valid/ready handshake toward execute.
module id_ex_operand_stage #(
  parameter int CTRL_W      = 16,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [31:0]            in_pc,
  input  logic [4:0]             in_rs1,
  input  logic [4:0]             in_rs2,
  input  logic                   in_use_rs1,
  input  logic                   in_use_rs2,
  input  logic [4:0]             in_rd,
  input  logic [31:0]            in_imm,
  input  logic [CTRL_W-1:0]      in_ctrl,
  output logic [4:0]             rf_a1,
  output logic [4:0]             rf_a2,
  input  logic [31:0]            rf_rd1,
  input  logic [31:0]            rf_rd2,
  input  logic                   ex_we,
  input  logic [4:0]             ex_rd,
  input  logic [31:0]            ex_data,
  input  logic                   ex_is_load,
  input  logic                   mem_we,
  input  logic [4:0]             mem_rd,
  input  logic [31:0]            mem_data,
  input  logic                   wb_we,
  input  logic [4:0]             wb_rd,
  input  logic [31:0]            wb_data,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            out_pc,
  output logic [31:0]            out_rs1_val,
  output logic [31:0]            out_rs2_val,
  output logic [31:0]            out_imm,
  output logic [4:0]             out_rd,
  output logic [CTRL_W-1:0]      out_ctrl,
  output logic [STALL_CNT_W-1:0] stall_cnt
);
  logic                   r_valid;
  logic [31:0]            r_pc, r_rs1_val, r_rs2_val, r_imm;
  logic [4:0]             r_rd;
  logic [CTRL_W-1:0]      r_ctrl;
  logic [STALL_CNT_W-1:0] r_stall_cnt;
  logic [31:0]            w_op1, w_op2;
  logic                   w_hazard, w_advance;
  // A load in EX has no data yet, so it never bypasses; the hazard logic stalls instead.
  always_comb begin
    w_op1 = in_rs1 == 5'd0 ? 32'd0 :
            (ex_we && !ex_is_load && ex_rd == in_rs1) ? ex_data :
            (mem_we && mem_rd == in_rs1) ? mem_data :
            (wb_we && wb_rd == in_rs1) ? wb_data : rf_rd1;
    w_op2 = in_rs2 == 5'd0 ? 32'd0 :
            (ex_we && !ex_is_load && ex_rd == in_rs2) ? ex_data :
            (mem_we && mem_rd == in_rs2) ? mem_data :
            (wb_we && wb_rd == in_rs2) ? wb_data : rf_rd2;
  end
  assign w_hazard  = in_valid && ex_is_load && ex_we && ex_rd != 5'd0 &&
                     ((in_use_rs1 && in_rs1 == ex_rd) || (in_use_rs2 && in_rs2 == ex_rd));
  assign w_advance = !r_valid || out_ready;
  assign in_ready  = flush || (w_advance && !w_hazard);
  assign rf_a1     = in_rs1;
  assign rf_a2     = in_rs2;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid     <= 1'b0;
      r_pc        <= '0;
      r_rs1_val   <= '0;
      r_rs2_val   <= '0;
      r_imm       <= '0;
      r_rd        <= '0;
      r_ctrl      <= '0;
      r_stall_cnt <= '0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_advance) begin
      if (w_hazard) begin
        r_valid     <= 1'b0;
        r_stall_cnt <= r_stall_cnt + {{(STALL_CNT_W-1){1'b0}}, ~&r_stall_cnt};
      end else begin
        r_valid <= in_valid;
        if (in_valid) begin
          r_pc      <= in_pc;
          r_rs1_val <= w_op1;
          r_rs2_val <= w_op2;
          r_imm     <= in_imm;
          r_rd      <= in_rd;
          r_ctrl    <= in_ctrl;
        end
      end
    end
  end
  assign out_valid   = r_valid;
  assign out_pc      = r_pc;
  assign out_rs1_val = r_rs1_val;
  assign out_rs2_val = r_rs2_val;
  assign out_imm     = r_imm;
  assign out_rd      = r_rd;
  assign out_ctrl    = r_ctrl;
  assign stall_cnt   = r_stall_cnt;
endmodule

// File: tb/tb_id_ex_operand_stage.sv
// tb_id_ex_operand_stage: directed vector table, handshake/flush/reset/saturation sequences,
// then random traffic checked against a behavioural model.
module tb_id_ex_operand_stage;
  localparam int CW = 16;
  localparam int SW = 4;
  logic clk = 0, rst = 0;
  logic in_valid, in_ready, in_use_rs1, in_use_rs2, ex_we, ex_is_load, mem_we, wb_we, flush;
  logic out_valid, out_ready;
  logic [31:0] in_pc, in_imm, rf_rd1, rf_rd2, ex_data, mem_data, wb_data;
  logic [31:0] out_pc, out_rs1_val, out_rs2_val, out_imm;
  logic [4:0] in_rs1, in_rs2, in_rd, rf_a1, rf_a2, ex_rd, mem_rd, wb_rd, out_rd;
  logic [CW-1:0] in_ctrl, out_ctrl;
  logic [SW-1:0] stall_cnt;
  int n_cmp = 0, n_err = 0;

  id_ex_operand_stage #(.CTRL_W(CW), .STALL_CNT_W(SW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_use_rs1(in_use_rs1), .in_use_rs2(in_use_rs2),
    .in_rd(in_rd), .in_imm(in_imm), .in_ctrl(in_ctrl), .rf_a1(rf_a1), .rf_a2(rf_a2),
    .rf_rd1(rf_rd1), .rf_rd2(rf_rd2), .ex_we(ex_we), .ex_rd(ex_rd), .ex_data(ex_data),
    .ex_is_load(ex_is_load), .mem_we(mem_we), .mem_rd(mem_rd), .mem_data(mem_data),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_pc(out_pc), .out_rs1_val(out_rs1_val),
    .out_rs2_val(out_rs2_val), .out_imm(out_imm), .out_rd(out_rd), .out_ctrl(out_ctrl),
    .stall_cnt(stall_cnt));

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] rs1, rs2; logic u1, u2; logic [31:0] rf1, rf2;
    logic exwe; logic [4:0] exrd; logic [31:0] exd; logic exl;
    logic memwe; logic [4:0] memrd; logic [31:0] memd;
    logic wbwe; logic [4:0] wbrd; logic [31:0] wbd; logic vld;
    logic rdy, ov; logic [31:0] v1, v2; logic [SW-1:0] sc;
  } vec_t;
  vec_t tbl[11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    in_valid = 0; in_pc = 0; in_rs1 = 0; in_rs2 = 0; in_use_rs1 = 0; in_use_rs2 = 0;
    in_rd = 0; in_imm = 0; in_ctrl = 0; rf_rd1 = 0; rf_rd2 = 0;
    ex_we = 0; ex_rd = 0; ex_data = 0; ex_is_load = 0; mem_we = 0; mem_rd = 0; mem_data = 0;
    wb_we = 0; wb_rd = 0; wb_data = 0; flush = 0; out_ready = 1;
  endtask

  task automatic do_reset();
    rst = 1; tick(); @(negedge clk); rst = 0;
  endtask

  // Reference model state
  logic m_valid; logic [31:0] m_pc, m_v1, m_v2, m_imm; logic [4:0] m_rd; logic [CW-1:0] m_ctrl;
  int m_sc;

  function automatic logic [31:0] resolve(input logic [4:0] s, input logic [31:0] rf);
    logic hit[3]; logic [31:0] d[3];
    hit[0] = ex_we && !ex_is_load && ex_rd == s; d[0] = ex_data;
    hit[1] = mem_we && mem_rd == s;              d[1] = mem_data;
    hit[2] = wb_we && wb_rd == s;                d[2] = wb_data;
    if (s == 0) return 0;
    for (int k = 0; k < 3; k++) if (hit[k]) return d[k];
    return rf;
  endfunction

  initial begin
    tbl[0]  = '{5,6,1,1,32'h11,32'h22, 0,0,0,0, 0,0,0, 0,0,0, 1, 1,1,32'h11,32'h22,0};
    tbl[1]  = '{7,6,1,1,32'h11,32'h22, 1,7,32'hA,0, 1,7,32'hB, 1,7,32'hC, 1, 1,1,32'hA,32'h22,0};
    tbl[2]  = '{7,6,1,1,32'h11,32'h22, 0,7,32'hA,0, 1,7,32'hB, 1,7,32'hC, 1, 1,1,32'hB,32'h22,0};
    tbl[3]  = '{7,6,1,1,32'h11,32'h22, 0,7,32'hA,0, 0,7,32'hB, 1,7,32'hC, 1, 1,1,32'hC,32'h22,0};
    tbl[4]  = '{0,6,1,1,32'h11,32'h22, 1,0,32'hA,0, 1,0,32'hB, 1,0,32'hC, 1, 1,1,32'h0,32'h22,0};
    tbl[5]  = '{5,9,1,1,32'h11,32'h22, 1,9,32'h99,1, 0,0,0, 0,0,0, 1, 0,0,32'h0,32'h22,1};
    tbl[6]  = '{5,9,1,1,32'h11,32'h22, 1,9,32'h99,0, 0,0,0, 0,0,0, 1, 1,1,32'h11,32'h99,1};
    tbl[7]  = '{5,9,1,0,32'h11,32'h22, 1,9,32'h99,1, 0,0,0, 0,0,0, 1, 1,1,32'h11,32'h22,1};
    tbl[8]  = '{0,0,1,1,32'h11,32'h22, 1,0,32'h55,1, 0,0,0, 0,0,0, 1, 1,1,32'h0,32'h0,1};
    tbl[9]  = '{4,3,1,0,32'h11,32'h22, 1,3,32'h66,1, 0,3,32'h88, 1,3,32'h77, 1, 1,1,32'h11,32'h77,1};
    tbl[10] = '{4,3,1,0,32'h11,32'h22, 0,0,0,0, 0,0,0, 0,0,0, 0, 1,0,32'h11,32'h77,1};

    idle();
    do_reset();
    chk("reset out_valid", out_valid, 0);
    chk("reset stall_cnt", stall_cnt, 0);
    chk("reset out_pc", out_pc, 0);

    foreach (tbl[i]) begin
      @(negedge clk);
      in_rs1 = tbl[i].rs1; in_rs2 = tbl[i].rs2; in_use_rs1 = tbl[i].u1; in_use_rs2 = tbl[i].u2;
      rf_rd1 = tbl[i].rf1; rf_rd2 = tbl[i].rf2; ex_we = tbl[i].exwe; ex_rd = tbl[i].exrd;
      ex_data = tbl[i].exd; ex_is_load = tbl[i].exl; mem_we = tbl[i].memwe;
      mem_rd = tbl[i].memrd; mem_data = tbl[i].memd; wb_we = tbl[i].wbwe;
      wb_rd = tbl[i].wbrd; wb_data = tbl[i].wbd; in_valid = tbl[i].vld;
      #1;
      chk($sformatf("vec%0d in_ready", i), in_ready, tbl[i].rdy);
      chk($sformatf("vec%0d rf_a1", i), rf_a1, tbl[i].rs1);
      tick();
      chk($sformatf("vec%0d out_valid", i), out_valid, tbl[i].ov);
      chk($sformatf("vec%0d rs1_val", i), out_rs1_val, tbl[i].v1);
      chk($sformatf("vec%0d rs2_val", i), out_rs2_val, tbl[i].v2);
      chk($sformatf("vec%0d stall_cnt", i), stall_cnt, tbl[i].sc);
    end

    // Backpressure: outputs frozen, hazard while blocked does not count
    @(negedge clk); idle(); do_reset();
    in_valid = 1; in_pc = 32'h100; in_rs1 = 5; in_use_rs1 = 1; rf_rd1 = 32'h11;
    in_imm = 32'h44; in_rd = 3; in_ctrl = 16'hBEEF; out_ready = 0;
    tick();
    chk("bp capture valid", out_valid, 1);
    chk("bp capture pc", out_pc, 32'h100);
    chk("bp capture imm", out_imm, 32'h44);
    chk("bp capture rd", out_rd, 3);
    chk("bp capture ctrl", out_ctrl, 16'hBEEF);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_pc = 32'h200 + i; rf_rd1 = $urandom; ex_is_load = 1; ex_we = 1; ex_rd = 5;
      #1 chk("bp in_ready", in_ready, 0);
      tick();
      chk("bp hold pc", out_pc, 32'h100);
      chk("bp hold rs1", out_rs1_val, 32'h11);
      chk("bp hold valid", out_valid, 1);
      chk("bp no stall count", stall_cnt, 0);
    end
    @(negedge clk);
    ex_is_load = 0; ex_we = 0; out_ready = 1; in_pc = 32'h300; rf_rd1 = 32'h33;
    #1 chk("bp release in_ready", in_ready, 1);
    tick();
    chk("bp release pc", out_pc, 32'h300);
    chk("bp release rs1", out_rs1_val, 32'h33);

    // Flush with a held instruction and a valid incoming one
    @(negedge clk); out_ready = 0; flush = 1; in_pc = 32'h400;
    #1 chk("flush in_ready", in_ready, 1);
    tick();
    chk("flush out_valid", out_valid, 0);

    // Async reset in the middle of a load-use stall
    @(negedge clk); flush = 0; out_ready = 1; ex_is_load = 1; ex_we = 1; ex_rd = 5;
    tick(); tick();
    chk("stall count 2", stall_cnt, 2);
    #2 rst = 1;
    #1;
    chk("async rst valid", out_valid, 0);
    chk("async rst stall_cnt", stall_cnt, 0);
    chk("async rst pc", out_pc, 0);
    @(negedge clk); rst = 0;

    // Saturation: 2^SW+2 hazard cycles
    repeat (14) tick();
    chk("stall count 14", stall_cnt, 14);
    repeat (4) tick();
    chk("stall saturated", stall_cnt, {SW{1'b1}});

    // Random traffic against the model
    @(negedge clk); idle(); do_reset();
    m_valid = 0; m_pc = 0; m_v1 = 0; m_v2 = 0; m_imm = 0; m_rd = 0; m_ctrl = 0; m_sc = 0;
    for (int c = 0; c < 400; c++) begin
      logic haz, adv, rdy;
      @(negedge clk);
      in_valid = $urandom_range(0, 3) != 0; in_pc = $urandom; in_imm = $urandom; in_ctrl = CW'($urandom);
      in_rs1 = 5'($urandom_range(0, 3)); in_rs2 = 5'($urandom_range(0, 3)); in_rd = 5'($urandom);
      in_use_rs1 = 1'($urandom); in_use_rs2 = 1'($urandom); rf_rd1 = $urandom; rf_rd2 = $urandom;
      ex_we = 1'($urandom); ex_rd = 5'($urandom_range(0, 3)); ex_data = $urandom;
      ex_is_load = $urandom_range(0, 2) == 0;
      mem_we = 1'($urandom); mem_rd = 5'($urandom_range(0, 3)); mem_data = $urandom;
      wb_we = 1'($urandom); wb_rd = 5'($urandom_range(0, 3)); wb_data = $urandom;
      flush = $urandom_range(0, 7) == 0; out_ready = $urandom_range(0, 3) != 0;
      haz = in_valid && ex_is_load && ex_we && ex_rd != 0 &&
            ((in_use_rs1 && in_rs1 == ex_rd) || (in_use_rs2 && in_rs2 == ex_rd));
      adv = !m_valid || out_ready;
      rdy = flush || (adv && !haz);
      #1;
      chk("rnd in_ready", in_ready, rdy);
      chk("rnd rf_a2", rf_a2, in_rs2);
      if (flush) m_valid = 0;
      else if (adv && haz) begin m_valid = 0; m_sc = m_sc < (1 << SW) - 1 ? m_sc + 1 : m_sc; end
      else if (adv && in_valid) begin
        m_valid = 1; m_pc = in_pc; m_imm = in_imm; m_rd = in_rd; m_ctrl = in_ctrl;
        m_v1 = resolve(in_rs1, rf_rd1); m_v2 = resolve(in_rs2, rf_rd2);
      end else if (adv) m_valid = 0;
      tick();
      chk("rnd out_valid", out_valid, m_valid);
      chk("rnd stall_cnt", stall_cnt, m_sc);
      if (m_valid) begin
        chk("rnd pc", out_pc, m_pc);
        chk("rnd rs1_val", out_rs1_val, m_v1);
        chk("rnd rs2_val", out_rs2_val, m_v2);
        chk("rnd imm", out_imm, m_imm);
        chk("rnd rd", out_rd, m_rd);
        chk("rnd ctrl", out_ctrl, m_ctrl);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/id_ex_operand_stage.md
Name: id_ex_operand_stage

Overview:
- Decode-to-execute pipeline stage directly downstream of the register file in risc_v_top.
- Drives the file's two asynchronous read addresses and captures the returned operands.
- Resolves read-after-write hazards by bypassing from EX, MEM and WB; stalls on load-use.
- Registers operands and control into the execute stage behind a valid/ready handshake with flush.

Parameters:
CTRL_W, 16, width of opaque decoded control bundle passed through to EX
STALL_CNT_W, 16, width of saturating load-use stall counter

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-high reset
in_valid  input  1  decoded instruction available
in_ready  output  1  stage accepts instruction this cycle
in_pc  input  32  instruction PC
in_rs1  input  5  source register 1 index
in_rs2  input  5  source register 2 index
in_use_rs1  input  1  instruction reads rs1
in_use_rs2  input  1  instruction reads rs2
in_rd  input  5  destination index
in_imm  input  32  sign-extended immediate
in_ctrl  input  CTRL_W  decoded control
rf_a1  output  5  register-file read address 1 (= in_rs1, combinational)
rf_a2  output  5  register-file read address 2 (= in_rs2, combinational)
rf_rd1  input  32  register-file read data 1
rf_rd2  input  32  register-file read data 2
ex_we  input  1  instruction in EX writes a register
ex_rd  input  5  EX destination
ex_data  input  32  EX ALU result
ex_is_load  input  1  EX instruction is a load (data not yet available)
mem_we  input  1  MEM writes a register
mem_rd  input  5  MEM destination
mem_data  input  32  MEM result
wb_we  input  1  WB write enable (same signal as register-file write enable)
wb_rd  input  5  WB destination
wb_data  input  32  WB write data
flush  input  1  discard held and incoming instruction
out_valid  output  1  EX-stage instruction valid
out_ready  input  1  EX accepts
out_pc  output  32  registered PC
out_rs1_val  output  32  resolved operand 1
out_rs2_val  output  32  resolved operand 2
out_imm  output  32  registered immediate
out_rd  output  5  registered destination
out_ctrl  output  CTRL_W  registered control
stall_cnt  output  STALL_CNT_W  saturating count of load-use stall cycles

Behaviour:
- Reset (async, immediate): out_valid=0; all out_* data = 0; stall_cnt = 0.
- Operand resolution per source s (combinational, same cycle as capture), priority:
  - s==0 gives 0.
  - ex_we && ex_rd==s && !ex_is_load gives ex_data.
  - Else mem_we && mem_rd==s gives mem_data.
  - Else wb_we && wb_rd==s gives wb_data. Required because the register file writes on the clock edge, so a same-cycle read returns the stale value.
  - Else rf_rd*.
- Load-use hazard: in_valid && ex_is_load && ex_we && ex_rd!=0 && ((in_use_rs1 && in_rs1==ex_rd) || (in_use_rs2 && in_rs2==ex_rd)).
- advance = !out_valid || out_ready.
- in_ready = flush || (advance && !hazard).
- Clock edge, in priority order:
  - flush: out_valid<=0; incoming instruction dropped.
  - advance && hazard: bubble inserted, out_valid<=0, data outputs hold; stall_cnt += 1, saturating at all-ones.
  - advance && in_valid: capture all fields, out_valid<=1.
  - advance && !in_valid: out_valid<=0.
  - !advance: all outputs hold, stable while out_valid && !out_ready.
- Hazard while !advance does not increment stall_cnt.
- Latency: one cycle from accepted input to out_valid.
- rf_a1/rf_a2 follow in_rs1/in_rs2 regardless of in_valid.
- Bypass inputs are sampled only in the capture cycle. A held instruction is not re-resolved; upstream keeps EX frozen while this stage is blocked.
- Reset mid-transfer discards the held instruction; no partial state survives.

Test Plan:
- Reset, then in_rs1=5, rs2=6, no bypass matches, rf_rd1=0x11, rf_rd2=0x22 -> next cycle out_valid=1, out_rs1_val=0x11, out_rs2_val=0x22, stall_cnt=0.
- rs1=7 with ex_rd=7 (ex_data=0xA), mem_rd=7 (0xB), wb_rd=7 (0xC), all we=1 -> out_rs1_val=0xA. Drop ex_we -> 0xB. Drop mem_we -> 0xC. rs1=0 with all matching -> 0.
- ex_is_load=1, ex_rd=9, in_rs2=9, in_use_rs2=1 -> in_ready=0, out_valid=0 next cycle, stall_cnt=1. Clear ex_is_load -> instruction captured with bypassed value.
- out_valid=1, out_ready=0 for 3 cycles with changing inputs -> outputs constant, in_ready=0. Raise out_ready -> new instruction captured next edge.
- flush with in_valid=1 and a held instruction -> in_ready=1, out_valid=0 next cycle. Assert rst asynchronously mid-stall -> out_valid=0 and stall_cnt=0 without waiting for a clock edge.
- Force 2^STALL_CNT_W+2 hazard cycles -> stall_cnt saturates at all-ones.
